// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Owner tags mark which requester a pending read belongs to.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    CPU_PRI   = 1'b0,
    DBG_FORCE = 1'b1
  } arb_state_e;

  localparam logic [1:0] TAG_CPU = 2'b10;
  localparam logic [1:0] TAG_DBG = 2'b01;
  localparam logic [1:0] TAG_NONE = 2'b00;

  localparam int unsigned MAX_WAIT_DEFAULT = 4;
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, debug and DMem-side signals around the arbiter.
// slave = arbiter view; master = requesters plus the memory model.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);

  logic          cpu_en;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive blocked debug cycles; force_o is raised in
// the cycle that the count reaches MAX_WAIT so the next cycle is a debug slot.
module dmem_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic blocked_i,
  output logic force_o
);

  localparam logic [WAIT_CNT_W-1:0] MaxCnt = WAIT_CNT_W'(MAX_WAIT);
  localparam logic [WAIT_CNT_W-1:0] OneCnt = WAIT_CNT_W'(1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle that is not a blocked debug request restarts the count.
  always_comb begin
    cnt_d = '0;
    if (blocked_i) begin
      cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + OneCnt;
    end
  end

  assign force_o = blocked_i && (cnt_d == MaxCnt);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port DMem between the CPU MEM stage (priority) and the
// debug port, with a starvation-forced debug slot and tagged read return.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  dmem_port_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic [1:0] rd_tag_q, rd_tag_d;

  logic cpu_gnt;
  logic dbg_gnt;
  logic cpu_stall;
  logic dbg_blocked;
  logic force_slot;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  // Grants are suppressed for the whole reset cycle.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        CPU_PRI: begin
          if (bus.cpu_en) begin
            cpu_gnt = 1'b1;
          end else if (bus.dbg_req) begin
            dbg_gnt = 1'b1;
          end
        end
        DBG_FORCE: begin
          dbg_gnt   = bus.dbg_req;
          cpu_stall = bus.cpu_en;
        end
        default: ;
      endcase
    end
  end

  assign dbg_blocked = !reset_i && (state_q == CPU_PRI) && bus.dbg_req && !dbg_gnt;

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .blocked_i (dbg_blocked),
    .force_o   (force_slot)
  );

  // The forced slot lasts exactly one cycle whether or not it gets used.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_PRI:   if (force_slot) state_d = DBG_FORCE;
      DBG_FORCE: state_d = CPU_PRI;
      default:   state_d = CPU_PRI;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_gnt) begin
      mem_en   = 1'b1;
      mem_we   = bus.cpu_we;
      mem_addr = bus.cpu_addr;
      mem_din  = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      mem_en   = 1'b1;
      mem_we   = bus.dbg_we;
      mem_addr = bus.dbg_addr;
      mem_din  = bus.dbg_wdata;
    end
  end

  always_comb begin
    rd_tag_d = TAG_NONE;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_tag_d = TAG_CPU;
    end else if (dbg_gnt && !bus.dbg_we) begin
      rd_tag_d = TAG_DBG;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= CPU_PRI;
      rd_tag_q <= TAG_NONE;
    end else begin
      state_q  <= state_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  assign bus.cpu_stall = cpu_stall;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_din   = mem_din;

  // Reset discards a read already in flight, including its return cycle.
  assign bus.cpu_rvalid = rd_tag_q[1] && !reset_i;
  assign bus.dbg_rvalid = rd_tag_q[0] && !reset_i;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_dout : '0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle-latency DMem model.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  dmem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  dmem_port_arbiter #(
    .AW       (16),
    .DW       (16),
    .MAX_WAIT (4)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [256];

  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 16'hBEEF;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
      else            bus.mem_dout <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cpu(input logic en, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_en    = en;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic dbg(input logic rq, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.dbg_req   = rq;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Requests present during reset must not be granted.
    settle();
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
    chk1("rst_cpu_stall", bus.cpu_stall, 1'b0);
    nxt();
    nxt();
    reset = 1'b0;
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("post_rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk1("post_rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    chk16("post_rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
    chk16("post_rst_dbg_rdata", bus.dbg_rdata, 16'h0000);
    chk1("post_rst_state", dut.state_q, CPU_PRI);
    chk16("post_rst_wait_cnt", 16'(dut.u_starve_ctr.cnt_q), 16'h0000);
    chk1("idle_mem_en", bus.mem_en, 1'b0);
    chk16("idle_mem_addr", bus.mem_addr, 16'h0000);

    // CPU-only read.
    nxt();
    cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    settle();
    chk1("cpu_rd_mem_en", bus.mem_en, 1'b1);
    chk1("cpu_rd_mem_we", bus.mem_we, 1'b0);
    chk16("cpu_rd_mem_addr", bus.mem_addr, 16'h0010);
    chk1("cpu_rd_stall", bus.cpu_stall, 1'b0);
    chk1("cpu_rd_dbg_gnt", bus.dbg_gnt, 1'b0);
    nxt();
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("cpu_rd_rvalid", bus.cpu_rvalid, 1'b1);
    chk16("cpu_rd_rdata", bus.cpu_rdata, 16'hBEEF);
    chk1("cpu_rd_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    chk16("cpu_rd_dbg_rdata", bus.dbg_rdata, 16'h0000);
    chk1("cpu_rd_idle_mem_en", bus.mem_en, 1'b0);

    // Debug write then read while the CPU is idle.
    nxt();
    dbg(1'b1, 1'b1, 16'h0020, 16'h1234);
    settle();
    chk1("dbg_wr_gnt", bus.dbg_gnt, 1'b1);
    chk1("dbg_wr_mem_en", bus.mem_en, 1'b1);
    chk1("dbg_wr_mem_we", bus.mem_we, 1'b1);
    chk16("dbg_wr_mem_addr", bus.mem_addr, 16'h0020);
    chk16("dbg_wr_mem_din", bus.mem_din, 16'h1234);
    nxt();
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);
    settle();
    chk1("dbg_rd_gnt", bus.dbg_gnt, 1'b1);
    chk1("dbg_rd_mem_we", bus.mem_we, 1'b0);
    chk1("dbg_wr_no_rvalid", bus.dbg_rvalid, 1'b0);
    nxt();
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("dbg_rd_rvalid", bus.dbg_rvalid, 1'b1);
    chk16("dbg_rd_rdata", bus.dbg_rdata, 16'h1234);
    chk1("dbg_rd_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk16("dbg_rd_cpu_rdata", bus.cpu_rdata, 16'h0000);

    // Full 16-bit address passes through untouched; writes give no rvalid.
    nxt();
    cpu(1'b1, 1'b1, 16'hABCD, 16'h5A5A);
    settle();
    chk16("wide_mem_addr", bus.mem_addr, 16'hABCD);
    chk1("wide_mem_we", bus.mem_we, 1'b1);
    chk16("wide_mem_din", bus.mem_din, 16'h5A5A);
    nxt();
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("cpu_wr_no_rvalid", bus.cpu_rvalid, 1'b0);

    // Starvation: four blocked cycles, forced slot, then CPU again.
    nxt();
    cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("starve_blocked_gnt", bus.dbg_gnt, 1'b0);
      chk1("starve_blocked_stall", bus.cpu_stall, 1'b0);
      chk16("starve_blocked_addr", bus.mem_addr, 16'h0010);
      chk16("starve_wait_cnt", 16'(dut.u_starve_ctr.cnt_q), 16'(k));
      nxt();
    end
    settle();
    chk1("force_dbg_gnt", bus.dbg_gnt, 1'b1);
    chk1("force_cpu_stall", bus.cpu_stall, 1'b1);
    chk16("force_mem_addr", bus.mem_addr, 16'h0020);
    chk1("force_state", dut.state_q, DBG_FORCE);
    chk1("interleave_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk16("interleave_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    chk1("interleave_dbg_rvalid_n1", bus.dbg_rvalid, 1'b0);
    nxt();
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("after_force_state", dut.state_q, CPU_PRI);
    chk1("after_force_gnt", bus.dbg_gnt, 1'b0);
    chk1("after_force_stall", bus.cpu_stall, 1'b0);
    chk16("after_force_addr", bus.mem_addr, 16'h0010);
    chk1("interleave_dbg_rvalid", bus.dbg_rvalid, 1'b1);
    chk16("interleave_dbg_rdata", bus.dbg_rdata, 16'h1234);
    chk1("interleave_cpu_rvalid_n2", bus.cpu_rvalid, 1'b0);
    chk16("after_force_wait_cnt", 16'(dut.u_starve_ctr.cnt_q), 16'h0000);
    nxt();
    settle();
    chk1("resume_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk1("resume_dbg_rvalid", bus.dbg_rvalid, 1'b0);

    // Dropping dbg_req restarts the starvation count.
    nxt();
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);
    settle();
    chk1("restart_gnt_a", bus.dbg_gnt, 1'b0);
    nxt();
    settle();
    chk1("restart_gnt_b", bus.dbg_gnt, 1'b0);
    nxt();
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk16("restart_cnt_before_drop", 16'(dut.u_starve_ctr.cnt_q), 16'h0002);
    nxt();
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("restart_blocked_gnt", bus.dbg_gnt, 1'b0);
      chk16("restart_wait_cnt", 16'(dut.u_starve_ctr.cnt_q), 16'(k));
      nxt();
    end
    settle();
    chk1("restart_forced_gnt", bus.dbg_gnt, 1'b1);
    nxt();
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Forced slot whose request has gone away stays idle.
    nxt();
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("drop_blocked_gnt", bus.dbg_gnt, 1'b0);
      nxt();
    end
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("drop_state", dut.state_q, DBG_FORCE);
    chk1("drop_mem_en", bus.mem_en, 1'b0);
    chk1("drop_cpu_stall", bus.cpu_stall, 1'b1);
    chk1("drop_dbg_gnt", bus.dbg_gnt, 1'b0);
    nxt();
    settle();
    chk1("drop_back_state", dut.state_q, CPU_PRI);
    chk1("drop_back_mem_en", bus.mem_en, 1'b1);
    chk1("drop_back_stall", bus.cpu_stall, 1'b0);
    chk1("drop_no_rvalid", bus.cpu_rvalid, 1'b0);
    chk16("drop_no_rdata", bus.cpu_rdata, 16'h0000);

    // Reset arriving the cycle after a granted CPU read.
    nxt();
    dbg(1'b1, 1'b0, 16'h0020, 16'h0000);
    settle();
    chk1("pre_rst_cpu_gnt", bus.mem_en, 1'b1);
    nxt();
    reset = 1'b1;
    settle();
    chk1("mid_rst_mem_en", bus.mem_en, 1'b0);
    chk1("mid_rst_stall", bus.cpu_stall, 1'b0);
    chk1("mid_rst_dbg_gnt", bus.dbg_gnt, 1'b0);
    chk1("mid_rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk16("mid_rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
    nxt();
    reset = 1'b0;
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    chk1("after_rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk1("after_rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    chk1("after_rst_state", dut.state_q, CPU_PRI);
    chk16("after_rst_wait_cnt", 16'(dut.u_starve_ctr.cnt_q), 16'h0000);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: the pipeline MEM stage (cpu_*) and the debug/loader port (dbg_*).
- The CPU has priority. The debug port uses a req/gnt handshake.
- A starvation counter forces one debug slot after MAX_WAIT blocked cycles; the CPU is stalled during that slot.
- Sits between the MEM-stage memory block and the DMem block-RAM instance. Read data returns one cycle after the access and is steered back to the requester that issued it.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_WAIT, 4, consecutive cycles dbg_req may be blocked before a debug slot is forced (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  CPU access request this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_stall  out  1  CPU access not taken this cycle; CPU holds the request.
- cpu_rdata  out  DW  read data to the CPU.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after the granted read).
- dbg_req  in  1  debug access request; held until granted.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  debug access taken this cycle.
- dbg_rdata  out  DW  read data to the debug port.
- dbg_rvalid  out  1  dbg_rdata valid.
- mem_en  out  1  to DMem ena.
- mem_we  out  1  to DMem wea.
- mem_addr  out  AW  to DMem addra.
- mem_din  out  DW  to DMem dina.
- mem_dout  in  DW  from DMem douta; 1-cycle read latency.

Behaviour:
- FSM, 2 states:
  - CPU_PRI (reset state).
  - DBG_FORCE.
- Grant logic, combinational from state and requests:
  - CPU_PRI:
    - cpu_en=1 → CPU granted; dbg_gnt=0.
    - cpu_en=0 and dbg_req=1 → debug granted.
  - DBG_FORCE:
    - dbg_req=1 → debug granted.
    - cpu_stall = cpu_en.
- Memory mux:
  - mem_en=1 only when a grant is issued.
  - mem_we/addr/din come from the granted requester.
  - With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Starvation counter wait_cnt (4 bits):
  - Increments each cycle in CPU_PRI with dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or dbg_req=0.
  - Saturates at MAX_WAIT.
- Transitions:
  - CPU_PRI → DBG_FORCE when wait_cnt reaches MAX_WAIT with dbg_req still high. The forced slot occurs the cycle after the MAX_WAIT-th blocked cycle.
  - DBG_FORCE → CPU_PRI after exactly one cycle, regardless of dbg_req. If dbg_req dropped, the slot is idle.
- Read return:
  - Registered tag rd_tag[1:0] = {cpu read granted, dbg read granted}.
  - Next cycle, cpu_rvalid/dbg_rvalid = tag bits.
  - cpu_rdata/dbg_rdata = mem_dout when the matching tag is set, else 0.
  - Writes produce no rvalid.
- Simultaneous events:
  - cpu_en and dbg_req in CPU_PRI → CPU wins; counter counts.
  - Back-to-back reads to different owners return in order, one per cycle.
- Reset (any cycle, including mid-access):
  - state=CPU_PRI, wait_cnt=0, rd_tag=0.
  - During reset all grants are suppressed: mem_en=0, dbg_gnt=0, cpu_stall=0.
  - Outputs in the cycle after reset: cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
  - A read in flight when reset is asserted is discarded.
- Address width rule: no truncation or offset. mem_addr equals the full 16-bit requester address; DMem depth decoding is outside this block.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {CPU_PRI, DBG_FORCE}.
  - Owner tag constants TAG_CPU=2'b10 and TAG_DBG=2'b01.
  - Default MAX_WAIT.
- One sub-module, dmem_starve_ctr: the saturating wait counter plus the force-flag output. The remainder stays flat in dmem_port_arbiter.

Test Plan:
- CPU-only:
  - Stimulus: cpu_en=1, cpu_we=0, addr=0x0010; DMem preloaded 0x0010=0xBEEF.
  - Response: mem_en=1 and mem_addr=0x0010 the same cycle; cpu_rvalid=1 and cpu_rdata=0xBEEF next cycle; cpu_stall=0 throughout.
- Debug while CPU idle:
  - Stimulus: dbg_req=1, dbg_we=1, addr=0x0020, wdata=0x1234; then a debug read of 0x0020.
  - Response: dbg_gnt=1 immediately; the read returns dbg_rvalid=1, dbg_rdata=0x1234.
- Starvation:
  - Stimulus: cpu_en=1 continuous, dbg_req=1, MAX_WAIT=4.
  - Response: dbg_gnt=0 for 4 cycles; 5th cycle dbg_gnt=1 and cpu_stall=1; 6th cycle CPU granted again and cpu_stall=0.
- Interleaved reads:
  - Stimulus: CPU read of 0x0010 in cycle N (value 0xBEEF); forced debug read of 0x0020 in cycle N+1 (value 0x1234).
  - Response: cpu_rvalid=1 with 0xBEEF at N+1 and dbg_rvalid=0 at N+1; dbg_rvalid=1 with 0x1234 at N+2; never both valid in the same cycle.
- Reset mid-read:
  - Stimulus: CPU read granted at cycle N; reset=1 at N+1.
  - Response: cpu_rvalid=0 at N+1 and N+2; state=CPU_PRI; wait_cnt=0; mem_en=0 while reset=1.
- Forced slot with dropped request:
  - Stimulus: dbg_req deasserted on the cycle the FSM enters DBG_FORCE.
  - Response: mem_en=0 and cpu_stall=cpu_en for that one cycle; FSM returns to CPU_PRI next cycle.
